// File: rtl/mux_word_sequencer.sv
// Feeder stage for a WIDTH:1 bit mux: double-buffers parallel words and walks the
// mux select across every bit of the active word with first/last framing and back-pressure.
module mux_word_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SEL_W = 2,
  parameter int unsigned HOLD  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] d,
  output logic [SEL_W-1:0] select,
  output logic             out_valid,
  output logic             out_first,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy
);

  localparam int unsigned CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [CNT_W-1:0] HCNT_MAX = CNT_W'(HOLD - 1);
  localparam logic [SEL_W-1:0] SEL_MAX  = SEL_W'(WIDTH - 1);

  logic [0:0]       state_q,     state_d;
  logic [WIDTH-1:0] act_word_q,  act_word_d;
  logic             pend_v_q,    pend_v_d;
  logic [WIDTH-1:0] pend_word_q, pend_word_d;
  logic [SEL_W-1:0] sel_q,       sel_d;
  logic [CNT_W-1:0] hcnt_q,      hcnt_d;

  logic act_v;
  logic accept;
  logic step;
  logic done;

  assign act_v  = (state_q == ST_SHIFT);
  assign accept = in_valid && in_ready;
  assign step   = act_v && out_ready && (hcnt_q == HCNT_MAX);
  assign done   = step && (sel_q == SEL_MAX);

  // Advance the bit walk, retire/refill the active word, route new words.
  always_comb begin
    state_d     = state_q;
    act_word_d  = act_word_q;
    pend_v_d    = pend_v_q;
    pend_word_d = pend_word_q;
    sel_d       = sel_q;
    hcnt_d      = hcnt_q;

    if (act_v && out_ready) begin
      if (hcnt_q == HCNT_MAX) begin
        hcnt_d = '0;
        sel_d  = done ? '0 : sel_q + SEL_W'(1);
      end else begin
        hcnt_d = hcnt_q + CNT_W'(1);
      end
    end

    if (done) begin
      if (pend_v_q) begin
        act_word_d = pend_word_q;
        pend_v_d   = 1'b0;
      end else begin
        state_d = ST_IDLE;
      end
    end

    // A word arriving on the final bit of the active word goes straight to active.
    if (accept) begin
      if ((!act_v || done) && !pend_v_q) begin
        state_d    = ST_SHIFT;
        act_word_d = in_data;
        sel_d      = '0;
        hcnt_d     = '0;
      end else begin
        pend_word_d = in_data;
        pend_v_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      act_word_q  <= '0;
      pend_v_q    <= 1'b0;
      pend_word_q <= '0;
      sel_q       <= '0;
      hcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      act_word_q  <= act_word_d;
      pend_v_q    <= pend_v_d;
      pend_word_q <= pend_word_d;
      sel_q       <= sel_d;
      hcnt_q      <= hcnt_d;
    end
  end

  // Status is forced quiet during reset so nothing leaks out of a discarded word.
  assign in_ready  = !rst && !pend_v_q;
  assign d         = act_word_q;
  assign select    = sel_q;
  assign out_valid = !rst && act_v;
  assign out_first = out_valid && (sel_q == '0);
  assign out_last  = out_valid && (sel_q == SEL_MAX);
  assign busy      = !rst && (act_v || pend_v_q);

endmodule

// File: tb/tb_mux_word_sequencer.sv
// Bench for mux_word_sequencer: directed vector table, a bit-level scoreboard on the
// HOLD=1 instance, a HOLD=3 instance for select dwell, and a random back-pressure run.
module tb_mux_word_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_ready, out_valid, out_first, out_last, out_ready, busy;
  logic [3:0] in_data, d;
  logic [1:0] select;

  logic       rst3, in_valid3, in_ready3, out_valid3, out_first3, out_last3, out_ready3, busy3;
  logic [3:0] in_data3, d3;
  logic [1:0] select3;

  mux_word_sequencer #(.WIDTH(4), .SEL_W(2), .HOLD(1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .d(d), .select(select), .out_valid(out_valid), .out_first(out_first),
    .out_last(out_last), .out_ready(out_ready), .busy(busy)
  );

  mux_word_sequencer #(.WIDTH(4), .SEL_W(2), .HOLD(3)) dut3 (
    .clk(clk), .rst(rst3), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .d(d3), .select(select3), .out_valid(out_valid3), .out_first(out_first3),
    .out_last(out_last3), .out_ready(out_ready3), .busy(busy3)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [3:0] word;
    logic [1:0] sel;
    logic       first;
    logic       last;
  } exp_t;

  exp_t sbq[$];

  // Scoreboard: each accepted word expands into four expected bit beats.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got beat d=%0h sel=%0d expected none", d, select);
      end else begin
        e = sbq.pop_front();
        check("sb_d", 32'(d), 32'(e.word));
        check("sb_sel", 32'(select), 32'(e.sel));
        check("sb_bit", 32'(d[select]), 32'(e.word[e.sel]));
        check("sb_first", 32'(out_first), 32'(e.first));
        check("sb_last", 32'(out_last), 32'(e.last));
      end
    end
    if (rst) begin
      sbq.delete();
    end else if (in_valid && in_ready) begin
      for (int i = 0; i < 4; i++) begin
        e.word  = in_data;
        e.sel   = 2'(i);
        e.first = (i == 0);
        e.last  = (i == 3);
        sbq.push_back(e);
      end
    end
  end

  typedef struct packed {
    logic       rst;
    logic       iv;
    logic [3:0] dat;
    logic       ordy;
    logic       chk_ds;
    logic       ir;
    logic       ov;
    logic [1:0] sel;
    logic [3:0] dd;
    logic       first;
    logic       last;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic iv, logic [3:0] dat, logic ordy, logic c,
                              logic ir, logic ov, logic [1:0] sel, logic [3:0] dd,
                              logic f, logic l, logic b);
    vec_t v;
    v.rst = r; v.iv = iv; v.dat = dat; v.ordy = ordy; v.chk_ds = c;
    v.ir = ir; v.ov = ov; v.sel = sel; v.dd = dd; v.first = f; v.last = l; v.busy = b;
    return v;
  endfunction

  logic acc;
  int   wait_cnt;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    rst3 = 1'b1; in_valid3 = 1'b0; in_data3 = '0; out_ready3 = 1'b1;

    //                rst iv dat  or chk ir ov sel d     f  l  busy
    vecs.push_back(mk(1, 0, 4'h0, 1, 0,  0, 0, 0, 4'h0, 0, 0, 0)); // reset, regs unknown
    vecs.push_back(mk(1, 0, 4'h0, 1, 1,  0, 0, 0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'hA, 1, 1,  1, 0, 0, 4'h0, 0, 0, 0)); // accept 1010
    vecs.push_back(mk(0, 0, 4'h0, 1, 1,  1, 1, 0, 4'hA, 1, 0, 1));
    vecs.push_back(mk(0, 0, 4'h0, 1, 1,  1, 1, 1, 4'hA, 0, 0, 1));
    vecs.push_back(mk(0, 0, 4'h0, 1, 1,  1, 1, 2, 4'hA, 0, 0, 1));
    vecs.push_back(mk(0, 0, 4'h0, 1, 1,  1, 1, 3, 4'hA, 0, 1, 1));
    vecs.push_back(mk(0, 1, 4'hA, 1, 1,  1, 0, 0, 4'hA, 0, 0, 0)); // idle, d held; accept A
    vecs.push_back(mk(0, 1, 4'h5, 1, 1,  1, 1, 0, 4'hA, 1, 0, 1)); // 5 -> pending
    vecs.push_back(mk(0, 1, 4'hF, 1, 1,  0, 1, 1, 4'hA, 0, 0, 1)); // F held off
    vecs.push_back(mk(0, 1, 4'hF, 1, 1,  0, 1, 2, 4'hA, 0, 0, 1));
    vecs.push_back(mk(0, 1, 4'hF, 1, 1,  0, 1, 3, 4'hA, 0, 1, 1));
    vecs.push_back(mk(0, 1, 4'hF, 1, 1,  1, 1, 0, 4'h5, 1, 0, 1)); // no bubble, F -> pending
    vecs.push_back(mk(0, 0, 4'h0, 1, 1,  0, 1, 1, 4'h5, 0, 0, 1));
    vecs.push_back(mk(0, 0, 4'h0, 1, 1,  0, 1, 2, 4'h5, 0, 0, 1));
    vecs.push_back(mk(0, 0, 4'h0, 1, 1,  0, 1, 3, 4'h5, 0, 1, 1));
    vecs.push_back(mk(0, 0, 4'h0, 1, 1,  1, 1, 0, 4'hF, 1, 0, 1));
    vecs.push_back(mk(0, 0, 4'h0, 1, 1,  1, 1, 1, 4'hF, 0, 0, 1));
    vecs.push_back(mk(0, 0, 4'h0, 0, 1,  1, 1, 2, 4'hF, 0, 0, 1)); // stall x3 at sel 2
    vecs.push_back(mk(0, 0, 4'h0, 0, 1,  1, 1, 2, 4'hF, 0, 0, 1));
    vecs.push_back(mk(0, 0, 4'h0, 0, 1,  1, 1, 2, 4'hF, 0, 0, 1));
    vecs.push_back(mk(0, 0, 4'h0, 1, 1,  1, 1, 2, 4'hF, 0, 0, 1));
    vecs.push_back(mk(0, 0, 4'h0, 1, 1,  1, 1, 3, 4'hF, 0, 1, 1));
    vecs.push_back(mk(0, 0, 4'h0, 1, 1,  1, 0, 0, 4'hF, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'h3, 1, 1,  1, 0, 0, 4'hF, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'h6, 1, 1,  1, 1, 0, 4'h3, 1, 0, 1)); // 6 -> pending
    vecs.push_back(mk(1, 0, 4'h0, 1, 0,  0, 0, 0, 4'h0, 0, 0, 0)); // reset mid-word
    vecs.push_back(mk(0, 1, 4'h9, 1, 1,  1, 0, 0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 1,  1, 1, 0, 4'h9, 1, 0, 1));
    vecs.push_back(mk(0, 0, 4'h0, 1, 1,  1, 1, 1, 4'h9, 0, 0, 1));
    vecs.push_back(mk(0, 0, 4'h0, 1, 1,  1, 1, 2, 4'h9, 0, 0, 1));
    vecs.push_back(mk(0, 1, 4'h2, 1, 1,  1, 1, 3, 4'h9, 0, 1, 1)); // done + accept
    vecs.push_back(mk(0, 0, 4'h0, 1, 1,  1, 1, 0, 4'h2, 1, 0, 1));
    vecs.push_back(mk(0, 0, 4'h0, 1, 1,  1, 1, 1, 4'h2, 0, 0, 1));
    vecs.push_back(mk(0, 0, 4'h0, 1, 1,  1, 1, 2, 4'h2, 0, 0, 1));
    vecs.push_back(mk(0, 0, 4'h0, 1, 1,  1, 1, 3, 4'h2, 0, 1, 1));
    vecs.push_back(mk(0, 0, 4'h0, 1, 1,  1, 0, 0, 4'h2, 0, 0, 0));

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; in_valid = vecs[i].iv; in_data = vecs[i].dat; out_ready = vecs[i].ordy;
      @(negedge clk);
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].ir));
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      check($sformatf("v%0d_first", i), 32'(out_first), 32'(vecs[i].first));
      check($sformatf("v%0d_last", i), 32'(out_last), 32'(vecs[i].last));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      if (vecs[i].chk_ds) begin
        check($sformatf("v%0d_select", i), 32'(select), 32'(vecs[i].sel));
        check($sformatf("v%0d_d", i), 32'(d), 32'(vecs[i].dd));
      end
      @(posedge clk); #1;
    end

    // HOLD=3: each select value dwells three cycles, word 1100.
    rst3 = 1'b0; in_valid3 = 1'b1; in_data3 = 4'hC;
    @(negedge clk);
    check("h3_in_ready", 32'(in_ready3), 1);
    check("h3_idle_valid", 32'(out_valid3), 0);
    @(posedge clk); #1;
    in_valid3 = 1'b0; in_data3 = '0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      check($sformatf("h3_c%0d_valid", k), 32'(out_valid3), (k <= 12) ? 1 : 0);
      check($sformatf("h3_c%0d_last", k), 32'(out_last3), (k >= 10 && k <= 12) ? 1 : 0);
      check($sformatf("h3_c%0d_first", k), 32'(out_first3), (k <= 3) ? 1 : 0);
      check($sformatf("h3_c%0d_d", k), 32'(d3), 32'hC);
      if (k <= 12) check($sformatf("h3_c%0d_sel", k), 32'(select3), (k - 1) / 3);
      @(posedge clk); #1;
    end

    // Random traffic with back-pressure; the scoreboard checks every beat.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (!(in_valid && !acc)) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 4'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end

    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk); #1;
    if (in_valid && !acc) begin
      wait_cnt = 0;
      while (!in_ready && wait_cnt < 20) begin
        out_ready = 1'b1;
        @(posedge clk); #1;
        wait_cnt++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_cnt = 0;
    while (busy && wait_cnt < 40) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    @(negedge clk);
    check("drain_busy", 32'(busy), 0);
    check("drain_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    check("sb_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
